pc_npc_unit: RTL and testbench

Program-counter stage of the SPARC datapath. Holds the architectural PC/nPC pair and advances it every cycle. Takes the branch target produced by the branch-address auxiliary adder (PC + sign-extended word displacement) and implements SPARC delayed-branch semantics: delay-slot execution, annul bit, branch-always annul and trap redirection. Feeds the fetch stage (`pc`) and the branch-address adder (`pc` as its base operand).

---
 rtl/pc_npc_if.sv | 28 ++
 rtl/pc_npc_unit.sv | 70 +++++++
 tb/tb_pc_npc_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pc_npc_if.sv
// pc_npc_if: control/address bundle between the PC stage and its neighbours.
//   stall/take_branch/uncond/annul_bit/target : branch and freeze controls from decode/adder
//   trap/trap_vec                             : trap redirect request
//   pc/npc/valid/annul_slot                   : registered PC-stage state toward fetch/adder
// master = the side driving controls (decode/trap logic), slave = the PC unit.
interface pc_npc_if;
  logic        stall;
  logic        take_branch;
  logic        uncond;
  logic        annul_bit;
  logic [31:0] target;
  logic        trap;
  logic [31:0] trap_vec;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        valid;
  logic        annul_slot;

  modport master (
    output stall, take_branch, uncond, annul_bit, target, trap, trap_vec,
    input  pc, npc, valid, annul_slot
  );

  modport slave (
    input  stall, take_branch, uncond, annul_bit, target, trap, trap_vec,
    output pc, npc, valid, annul_slot
  );
endinterface

// File: rtl/pc_npc_unit.sv
// pc_npc_unit: SPARC PC/nPC pair with delayed-branch, annul and trap redirect.
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset
//   bus   : pc_npc_if.slave (controls in, pc/npc/valid/annul_slot out)
// All outputs come straight from registers.
module pc_npc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       reset,
  pc_npc_if.slave    bus
);
  typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

  state_t      r_state, w_nxt_state;
  logic [31:0] r_pc, r_npc, w_nxt_pc, w_nxt_npc;
  logic        r_annul, w_nxt_annul;
  logic [31:0] w_tgt, w_vec;
  logic        w_eff_br;

  assign w_tgt = {bus.target[31:2], 2'b00};
  assign w_vec = {bus.trap_vec[31:2], 2'b00};
  // An annulled slot can neither redirect nor annul its successor.
  assign w_eff_br = bus.take_branch & ~r_annul;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pc    = r_pc;
    w_nxt_npc   = r_npc;
    w_nxt_annul = r_annul;
    case (r_state)
      BOOT: w_nxt_state = RUN;
      TRAP: w_nxt_state = RUN;
      RUN: begin
        if (bus.trap) begin
          // Trap wins over stall and any concurrent branch.
          w_nxt_pc    = w_vec;
          w_nxt_npc   = w_vec + 32'd4;
          w_nxt_annul = 1'b0;
          w_nxt_state = TRAP;
        end else if (!bus.stall) begin
          w_nxt_pc    = r_npc;
          w_nxt_npc   = w_eff_br ? w_tgt : r_npc + 32'd4;
          // Untaken conditional or BA,a annuls the slot; taken cond with a=1 runs it.
          w_nxt_annul = ~r_annul & bus.annul_bit & (~bus.take_branch | bus.uncond);
        end
      end
      default: w_nxt_state = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_npc   <= RESET_PC + 32'd4;
      r_annul <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_pc    <= w_nxt_pc;
      r_npc   <= w_nxt_npc;
      r_annul <= w_nxt_annul;
    end
  end

  assign bus.pc         = r_pc;
  assign bus.npc        = r_npc;
  assign bus.valid      = (r_state == RUN);
  assign bus.annul_slot = r_annul;
endmodule

// File: tb/tb_pc_npc_unit.sv
module tb_pc_npc_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  pc_npc_if bus ();
  pc_npc_unit #(.RESET_PC(32'h0)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall = 0; bus.take_branch = 0; bus.uncond = 0; bus.annul_bit = 0;
    bus.target = 32'h0; bus.trap = 0; bus.trap_vec = 32'h0;
  endtask

  // Reset, release, and advance until pc == 8.
  task automatic go_to8();
    idle();
    reset = 1; step();
    reset = 0; step(); step(); step();
    chk("go8_pc", bus.pc, 32'd8);
  endtask

  task automatic br(input logic tb_, input logic u, input logic a, input logic [31:0] t);
    bus.take_branch = tb_; bus.uncond = u; bus.annul_bit = a; bus.target = t;
  endtask

  initial begin
    idle();
    reset = 1;
    step(); step();
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_npc", bus.npc, 32'h4);
    chk("rst_valid", {31'b0, bus.valid}, 32'h0);
    chk("rst_annul", {31'b0, bus.annul_slot}, 32'h0);

    // Release: BOOT cycle first, then sequential fetch.
    reset = 0;
    chk("boot_valid", {31'b0, bus.valid}, 32'h0);
    step();
    chk("run_valid", {31'b0, bus.valid}, 32'h1);
    chk("seq0", bus.pc, 32'd0);
    step(); chk("seq4", bus.pc, 32'd4);
    step(); chk("seq8", bus.pc, 32'd8);

    // Taken branch, no annul.
    br(1, 0, 0, 32'h40);
    step(); idle();
    chk("br_slot", bus.pc, 32'd12);
    chk("br_slot_ann", {31'b0, bus.annul_slot}, 32'h0);
    step(); chk("br_tgt", bus.pc, 32'h40);
    step(); chk("br_tgt4", bus.pc, 32'h44);

    // Untaken with a=1, then annulled slot carrying a branch that must be ignored.
    go_to8();
    br(0, 0, 1, 32'h40);
    step();
    chk("unt_pc", bus.pc, 32'd12);
    chk("unt_ann", {31'b0, bus.annul_slot}, 32'h1);
    br(1, 1, 1, 32'h80);
    step(); idle();
    chk("anslot_pc", bus.pc, 32'd16);
    chk("anslot_npc", bus.npc, 32'd20);
    chk("anslot_ann", {31'b0, bus.annul_slot}, 32'h0);
    step(); chk("anslot_pc2", bus.pc, 32'd20);

    // BA,a: slot annulled, target still taken.
    go_to8();
    br(1, 1, 1, 32'h40);
    step(); idle();
    chk("baa_pc", bus.pc, 32'd12);
    chk("baa_ann", {31'b0, bus.annul_slot}, 32'h1);
    step();
    chk("baa_tgt", bus.pc, 32'h40);
    chk("baa_ann2", {31'b0, bus.annul_slot}, 32'h0);

    // Taken conditional, a=1: slot executes.
    go_to8();
    br(1, 0, 1, 32'h40);
    step(); idle();
    chk("tca_pc", bus.pc, 32'd12);
    chk("tca_ann", {31'b0, bus.annul_slot}, 32'h0);
    step(); chk("tca_tgt", bus.pc, 32'h40);

    // Trap beats stall and branch at pc = 0x20.
    go_to8();
    repeat (6) step();
    chk("pre_trap_pc", bus.pc, 32'h20);
    bus.trap = 1; bus.stall = 1; bus.trap_vec = 32'h103;
    br(1, 0, 0, 32'h40);
    step();
    bus.stall = 0; br(0, 0, 0, 32'h0);
    chk("trap_pc", bus.pc, 32'h100);
    chk("trap_npc", bus.npc, 32'h104);
    chk("trap_valid", {31'b0, bus.valid}, 32'h0);
    step();
    chk("trap_valid2", {31'b0, bus.valid}, 32'h1);
    chk("trap_pc2", bus.pc, 32'h100);
    bus.trap = 0;
    step(); chk("trap_pc3", bus.pc, 32'h104);

    // Stall holds state with valid high.
    bus.stall = 1; br(1, 0, 0, 32'h200);
    step();
    chk("stall_pc", bus.pc, 32'h104);
    chk("stall_npc", bus.npc, 32'h108);
    chk("stall_valid", {31'b0, bus.valid}, 32'h1);
    idle();
    step(); chk("unstall_pc", bus.pc, 32'h108);

    // Wrap: branch to 0xFFFFFFF8 (low bits of target dropped), npc wraps to 0.
    br(1, 0, 0, 32'hFFFF_FFFB);
    step(); idle();
    chk("wr_npc0", bus.npc, 32'hFFFF_FFF8);
    step(); chk("wr_npc1", bus.npc, 32'hFFFF_FFFC);
    step();
    chk("wr_pc", bus.pc, 32'hFFFF_FFFC);
    chk("wr_npc", bus.npc, 32'h0);
    step(); chk("wr_pc0", bus.pc, 32'h0);

    // Reset the cycle after a taken branch: target discarded.
    go_to8();
    br(1, 0, 0, 32'h40);
    step(); idle();
    chk("mid_npc", bus.npc, 32'h40);
    reset = 1;
    step();
    chk("mid_rst_pc", bus.pc, 32'h0);
    chk("mid_rst_npc", bus.npc, 32'h4);
    chk("mid_rst_ann", {31'b0, bus.annul_slot}, 32'h0);
    chk("mid_rst_valid", {31'b0, bus.valid}, 32'h0);
    reset = 0;
    step(); chk("mid_pc0", bus.pc, 32'h0);
    step(); chk("mid_pc4", bus.pc, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
